// File: rtl/multdiv_sequencer_if.sv
// Start/busy/done bus between execute and the multiply/divide sequencer.
// The master launches operations; the slave returns tagged results.
interface multdiv_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [TAG_W-1:0] tag_in;
    logic             abort;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start_mult, start_div, op_a, op_b, tag_in, abort,
        input  busy, result_valid, result, exception, tag_out
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b, tag_in, abort,
        output busy, result_valid, result, exception, tag_out
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide with start/busy/done and tag passthrough.
// MULTDIV_EARLY_OUT_EN: zero-operand multiplies/divides finish in one cycle.
module multdiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int STEPS = 1
) (
    input logic clock,
    input logic reset,
    multdiv_sequencer_if.slave bus
);
    localparam int ITER = WIDTH / STEPS;
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] ITER_C = CW'(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;

    logic             is_div, neg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi, lo, dvs;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   acc;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
    logic             exc;
    logic [TAG_W-1:0] tag_res;

    logic             load, step, fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_exc;
    logic [TAG_W-1:0] fin_tag;
    logic             one_start, zero_div, early;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH-1:0] quo;
    logic             mul_ovf;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Both ops work on magnitudes; sign is applied once at the end.
    always_comb begin
        hi_d = hi;
        lo_d = lo;
        acc  = '0;
        for (int s = 0; s < STEPS; s++) begin
            if (is_div) begin
                acc  = {hi_d, lo_d[WIDTH-1]};
                lo_d = {lo_d[WIDTH-2:0], 1'b0};
                if (acc >= {1'b0, dvs}) begin
                    acc     = acc - {1'b0, dvs};
                    lo_d[0] = 1'b1;
                end
                hi_d = acc[WIDTH-1:0];
            end else begin
                acc  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, dvs} : '0);
                lo_d = {acc[0], lo_d[WIDTH-1:1]};
                hi_d = acc[WIDTH:1];
            end
        end
    end

    assign sprod   = neg ? -{hi, lo} : {hi, lo};
    assign quo     = neg ? -lo : lo;
    assign mul_ovf = !((&sprod[2*WIDTH-1:WIDTH-1]) ||
                       !(|sprod[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        fin_res   = '0;
        fin_exc   = 1'b0;
        fin_tag   = bus.tag_in;
        one_start = bus.start_mult ^ bus.start_div;
        zero_div  = bus.start_div && (bus.op_b == '0);
`ifdef MULTDIV_EARLY_OUT_EN
        early = bus.start_mult
              ? (bus.op_a == '0 || bus.op_b == '0)
              : (bus.op_a == '0 && bus.op_b != '0);
`else
        early = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!bus.abort && one_start) begin
                    if (zero_div || early) begin
                        state_d = DONE;
                        fin     = 1'b1;
                        fin_exc = zero_div;
                    end else begin
                        state_d = RUN;
                        load    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (count == '0) begin
                    state_d = DONE;
                    fin     = 1'b1;
                    fin_tag = tag;
                    fin_res = is_div ? quo : sprod[WIDTH-1:0];
                    fin_exc = is_div ? (!neg && lo[WIDTH-1]) : mul_ovf;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_div  <= 1'b0;
            neg     <= 1'b0;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            dvs     <= '0;
            tag     <= '0;
            res     <= '0;
            exc     <= 1'b0;
            tag_res <= '0;
        end else begin
            if (load) begin
                is_div <= bus.start_div;
                neg    <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                count  <= ITER_C;
                hi     <= '0;
                lo     <= bus.start_div ? mag(bus.op_a) : mag(bus.op_b);
                dvs    <= bus.start_div ? mag(bus.op_b) : mag(bus.op_a);
                tag    <= bus.tag_in;
            end else if (step) begin
                hi    <= hi_d;
                lo    <= lo_d;
                count <= count - 1'b1;
            end
            if (fin) begin
                res     <= fin_res;
                exc     <= fin_exc;
                tag_res <= fin_tag;
            end
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = res;
    assign bus.exception    = exc;
    assign bus.tag_out      = tag_res;
endmodule
